get_bit: RTL
============

GET_BIT -- requirements
Module: get_bit

Interface
REQ-001 Parameter: BUF_BITS, 64, bit-buffer capacity in bits (multiple of 8, >= 40).
REQ-002 clock  input  1  single clock, all logic on rising edge.
REQ-003 reset_n  input  1  reset; synchronous and active-low.
REQ-004 in_valid  input  1  in_byte carries a stream byte.
REQ-005 in_byte  input  8  stream byte; bit 7 is the first bit in stream order.
REQ-006 in_ready  output  1  block can accept a byte this cycle.
REQ-007 req_valid  input  1  request to extract req_size bits.
REQ-008 req_size  input  6  bits to extract, 0..32.
REQ-009 req_ready  output  1  request is accepted this cycle if req_valid.
REQ-010 align  input  1  discard bits up to the next byte boundary; inverse of the packer's flush_bit.
REQ-011 out_valid  output  1  one-cycle pulse; out_val is valid.
REQ-012 out_val  output  32  extracted bits, right-aligned, zero-extended.
REQ-013 fill_level  output  7  valid bits currently buffered.
REQ-014 bit_offset  output  32  total bits consumed since reset, including aligned-away bits.
REQ-015 lz_count  output  6  leading zeros at buffer head. Present only with the macro.

Function
REQ-016 Bit order: MSB-first; the first bit of the first accepted byte is the first bit extracted.
REQ-017 in_ready = (fill_level <= BUF_BITS-8), evaluated on the pre-cycle fill_level.
  - Byte accepted on in_valid && in_ready.
  - in_valid with in_ready low: byte ignored; the source holds it.
REQ-018 req_ready = (fill_level >= req_size) && !align, evaluated on the pre-cycle fill_level.
  - A byte pushed in the same cycle does not count toward req_ready.
REQ-019 Accepted request: out_valid=1 on the next cycle, with out_val = the next req_size buffered bits; latency exactly 1.
  - out_valid is 0 in all other cycles.
REQ-020 req_size=0: accepted whenever align is low; next cycle out_valid=1, out_val=0; fill_level and bit_offset unchanged.
REQ-021 req_size 33..63: illegal; treated as 32.
REQ-022 Simultaneous push and extract: fill_level' = fill_level + 8 - req_size; bit order preserved.
REQ-023 align: discard (bit_offset mod 8) complement bits, i.e. (8 - bit_offset%8)%8 bits, in one cycle.
  - Any accompanying req_valid is not accepted.
  - A push in the same cycle is still accepted.
  - Already aligned: no-op.
REQ-024 bit_offset: 32-bit, increments by bits consumed each cycle, wraps modulo 2^32.
REQ-025 fill_level never exceeds BUF_BITS and never goes negative under legal handshakes.

Reset
REQ-026 With reset_n low at a rising edge:
  - buffer empty; fill_level=0; bit_offset=0; out_valid=0; out_val=0; lz_count=0.
  - in_ready=1; req_ready=1 only for req_size=0.
REQ-027 Reset mid-operation discards all buffered bits and any pending output; no out_valid pulse follows reset.

Configuration
REQ-028 Macro GET_BIT_LEADING_ZERO_EN.
  - Defined: lz_count port exists. It is a combinational count of consecutive zeros from the buffer head, saturating at min(fill_level, 32). It supports the exp-Golomb/Rice decoders.
  - Undefined: port and logic are absent; all other behaviour is identical.

Verification
REQ-029 Push 0xA5,0x3C; req 4 -> out_val=0xA; req 7 -> out_val=0x29; fill_level=5, bit_offset=11; align -> fill_level=0, bit_offset=16.
REQ-030 Push 0xDE,0xAD,0xBE,0xEF; req 32 -> out_val=0xDEADBEEF one cycle later; fill_level=0.
REQ-031 Push 8 bytes with no reads -> fill_level=64, in_ready=0. A 9th byte with in_valid held is not accepted until req 8 completes; then out_val = first byte.
REQ-032 fill_level=3 with req 8 and a simultaneous push -> req_ready=0 that cycle; next cycle req accepted; fill_level ends at 3.
REQ-033 GET_BIT_LEADING_ZERO_EN defined: push 0x00,0x1F -> lz_count=11; req 11 -> lz_count=0.
REQ-034 Reset asserted one cycle after a req is accepted -> out_valid=0, fill_level=0, bit_offset=0 on the following cycle.

Source files
------------

// File: rtl/get_bit.sv
// MSB-first bit extractor: bytes in, 0..32-bit fields out one cycle after acceptance.
// Optional GET_BIT_LEADING_ZERO_EN adds a lz_count port for exp-Golomb/Rice decoding.
module get_bit #(
    parameter int BUF_BITS = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    input  logic        req_valid,
    input  logic [5:0]  req_size,
    output logic        req_ready,
    input  logic        align,
    output logic        out_valid,
    output logic [31:0] out_val,
    output logic [6:0]  fill_level,
    output logic [31:0] bit_offset
`ifdef GET_BIT_LEADING_ZERO_EN
    ,
    output logic [5:0]  lz_count
`endif
);

    localparam logic [6:0] PUSH_MAX = 7'(BUF_BITS - 8);

    // Valid bits sit left-justified; everything below fill_q is kept zero.
    logic [BUF_BITS-1:0] buf_q, buf_d;
    logic [6:0]          fill_q, fill_d;
    logic [31:0]         offset_q, offset_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_val_q, out_val_d;

    logic [5:0]  size_eff;
    logic [31:0] head;
    logic        push;
    logic        req_acc;
    logic [5:0]  consume;
    logic [6:0]  remain;

    assign size_eff  = (req_size > 6'd32) ? 6'd32 : req_size;
    assign head      = buf_q[BUF_BITS-1 -: 32];
    assign in_ready  = (fill_q <= PUSH_MAX);
    assign req_ready = ({1'b0, size_eff} <= fill_q) && !align;

    always_comb begin
        push    = in_valid && in_ready;
        req_acc = req_valid && req_ready;
        // Aligning drops exactly the bits left over from the current partial byte.
        if (align) begin
            consume = {3'b000, 3'(3'd0 - offset_q[2:0])};
        end else if (req_acc) begin
            consume = size_eff;
        end else begin
            consume = 6'd0;
        end
        remain = fill_q - {1'b0, consume};
        buf_d  = buf_q << consume;
        if (push) begin
            buf_d = buf_d | ({in_byte, {(BUF_BITS-8){1'b0}}} >> remain);
        end
        fill_d      = remain + (push ? 7'd8 : 7'd0);
        offset_d    = offset_q + {26'd0, consume};
        out_valid_d = req_acc;
        out_val_d   = req_acc ? (head >> (6'd32 - size_eff)) : 32'd0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            buf_q       <= '0;
            fill_q      <= 7'd0;
            offset_q    <= 32'd0;
            out_valid_q <= 1'b0;
            out_val_q   <= 32'd0;
        end else begin
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            offset_q    <= offset_d;
            out_valid_q <= out_valid_d;
            out_val_q   <= out_val_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_val    = out_val_q;
    assign fill_level = fill_q;
    assign bit_offset = offset_q;

`ifdef GET_BIT_LEADING_ZERO_EN
    logic [5:0] lz_raw;
    logic       lz_hit;

    // Zero padding below the valid bits is counted too, so clamp to fill_q.
    always_comb begin
        lz_raw = 6'd0;
        lz_hit = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!lz_hit) begin
                if (head[i]) begin
                    lz_hit = 1'b1;
                end else begin
                    lz_raw = lz_raw + 6'd1;
                end
            end
        end
        lz_count = ({1'b0, lz_raw} > fill_q) ? fill_q[5:0] : lz_raw;
    end
`endif

endmodule
